// File: rtl/bus_grant_scheduler_if.sv
// Request/grant bundle between the per-master port decoders, the scheduler and the bus muxes.
// The scheduler uses the slave modport; the request side uses the master modport.
interface bus_grant_scheduler_if #(
  parameter int NO_MASTERS = 2,
  parameter int NO_SLAVES  = 3,
  parameter int S_ID_WIDTH = $clog2(NO_SLAVES + 1),
  parameter int M_ID_WIDTH = $clog2(NO_MASTERS)
) ();
  logic [NO_MASTERS-1:0]            req;
  logic [NO_MASTERS*S_ID_WIDTH-1:0] req_slave;
  logic [NO_MASTERS-1:0]            done;
  logic [NO_MASTERS-1:0]            grant;
  logic [NO_MASTERS-1:0]            preempt;
  logic [M_ID_WIDTH-1:0]            master_select;
  logic [S_ID_WIDTH-1:0]            slave_select;
  logic [S_ID_WIDTH+M_ID_WIDTH-1:0] bus_state;
  logic                             bus_busy;

  modport slave (
    input  req, req_slave, done,
    output grant, preempt, master_select, slave_select, bus_state, bus_busy
  );

  modport master (
    output req, req_slave, done,
    input  grant, preempt, master_select, slave_select, bus_state, bus_busy
  );
endinterface

// File: rtl/bus_grant_scheduler.sv
// Round-robin bus-ownership scheduler: one owner at a time, registered mux selects and bus_state.
// Define SCHED_PREEMPT_EN to build the PREEMPT state that asks a long-holding owner to release.
module bus_grant_scheduler #(
  parameter int NO_MASTERS = 2,
  parameter int NO_SLAVES  = 3,
  parameter int THRESH     = 1000,
  parameter int S_ID_WIDTH = $clog2(NO_SLAVES + 1),
  parameter int M_ID_WIDTH = $clog2(NO_MASTERS)
) (
  input logic                  clk,
  input logic                  rst,
  bus_grant_scheduler_if.slave bus
);
  localparam int H_WIDTH = $clog2(THRESH + 1);

`ifdef SCHED_PREEMPT_EN
  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_PREEMPT, S_RELEASE} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_RELEASE} state_e;
`endif

  state_e                           state_q, state_d;
  logic [NO_MASTERS-1:0]            grant_q, grant_d;
  logic [M_ID_WIDTH-1:0]            master_select_q, master_select_d;
  logic [S_ID_WIDTH-1:0]            slave_select_q, slave_select_d;
  logic [S_ID_WIDTH+M_ID_WIDTH-1:0] bus_state_q, bus_state_d;
  logic                             bus_busy_q, bus_busy_d;
  logic [M_ID_WIDTH-1:0]            rr_ptr_q, rr_ptr_d;
  logic [H_WIDTH-1:0]               hold_cnt_q, hold_cnt_d;

  logic [NO_MASTERS-1:0]            valid;
  logic                             win_found;
  logic [M_ID_WIDTH-1:0]            win_idx;
  logic                             owner_release;

  // A request only counts when its slave ID names a real slave.
  for (genvar gi = 0; gi < NO_MASTERS; gi++) begin : g_valid
    assign valid[gi] = bus.req[gi]
                    && (bus.req_slave[gi*S_ID_WIDTH +: S_ID_WIDTH] != '0)
                    && (32'(bus.req_slave[gi*S_ID_WIDTH +: S_ID_WIDTH]) <= 32'(NO_SLAVES));
  end

  // Scan from the farthest candidate back to rr_ptr so the nearest valid one wins.
  always_comb begin
    int unsigned p;
    p         = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = NO_MASTERS - 1; k >= 0; k--) begin
      p = 32'(rr_ptr_q) + 32'(k);
      if (p >= 32'(NO_MASTERS)) p = p - 32'(NO_MASTERS);
      if (valid[p]) begin
        win_found = 1'b1;
        win_idx   = M_ID_WIDTH'(p);
      end
    end
  end

  assign owner_release = bus.done[master_select_q] || !bus.req[master_select_q];

`ifdef SCHED_PREEMPT_EN
  logic [NO_MASTERS-1:0] preempt_q, preempt_d;
  logic                  other_pending;
  assign other_pending = |(valid & ~grant_q);
`endif

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    master_select_d = master_select_q;
    slave_select_d  = slave_select_q;
    bus_busy_d      = bus_busy_q;
    rr_ptr_d        = rr_ptr_q;
    hold_cnt_d      = hold_cnt_q;
`ifdef SCHED_PREEMPT_EN
    preempt_d       = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d         = S_ACTIVE;
          grant_d         = {{(NO_MASTERS-1){1'b0}}, 1'b1} << win_idx;
          master_select_d = win_idx;
          slave_select_d  = bus.req_slave[win_idx*S_ID_WIDTH +: S_ID_WIDTH];
          bus_busy_d      = 1'b1;
          hold_cnt_d      = '0;
        end
      end
      S_ACTIVE: begin
        if (hold_cnt_q != H_WIDTH'(THRESH)) hold_cnt_d = hold_cnt_q + 1'b1;
        if (owner_release) begin
          state_d        = S_RELEASE;
          grant_d        = '0;
          slave_select_d = '0;
          bus_busy_d     = 1'b0;
        end
`ifdef SCHED_PREEMPT_EN
        else if (hold_cnt_q == H_WIDTH'(THRESH) && other_pending) begin
          state_d   = S_PREEMPT;
          preempt_d = grant_q;
        end
`endif
      end
`ifdef SCHED_PREEMPT_EN
      S_PREEMPT: begin
        if (owner_release) begin
          state_d        = S_RELEASE;
          grant_d        = '0;
          slave_select_d = '0;
          bus_busy_d     = 1'b0;
        end
      end
`endif
      S_RELEASE: begin
        state_d  = S_IDLE;
        rr_ptr_d = (master_select_q == M_ID_WIDTH'(NO_MASTERS - 1)) ? '0
                                                                    : master_select_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    bus_state_d = bus_busy_d ? {slave_select_d, master_select_d} : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      grant_q         <= '0;
      master_select_q <= '0;
      slave_select_q  <= '0;
      bus_state_q     <= '0;
      bus_busy_q      <= 1'b0;
      rr_ptr_q        <= '0;
      hold_cnt_q      <= '0;
    end else begin
      state_q         <= state_d;
      grant_q         <= grant_d;
      master_select_q <= master_select_d;
      slave_select_q  <= slave_select_d;
      bus_state_q     <= bus_state_d;
      bus_busy_q      <= bus_busy_d;
      rr_ptr_q        <= rr_ptr_d;
      hold_cnt_q      <= hold_cnt_d;
    end
  end

`ifdef SCHED_PREEMPT_EN
  always_ff @(posedge clk) begin
    if (rst) preempt_q <= '0;
    else     preempt_q <= preempt_d;
  end
  assign bus.preempt = preempt_q;
`else
  assign bus.preempt = '0;
`endif

  assign bus.grant         = grant_q;
  assign bus.master_select = master_select_q;
  assign bus.slave_select  = slave_select_q;
  assign bus.bus_state     = bus_state_q;
  assign bus.bus_busy      = bus_busy_q;
endmodule
